ct_ram_arbiter: RTL and testbench

- Round-robin Wishbone B3 arbiter that shares one compute-tile RAM slave port between NUM_MASTERS bus masters, for example instruction bus, data bus and DMA.
- Sits between the tile bus masters and the tile RAM.
- A grant is held for the whole Wishbone cycle (cyc high), including incrementing, wrapping and constant-address bursts, so the RAM's burst address tracking is never interrupted.

---
 rtl/ct_ram_arbiter_if.sv | 47 ++++
 rtl/ct_ram_arbiter.sv | 70 +++++++
 tb/tb_ct_ram_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ct_ram_arbiter_if.sv
// ct_ram_arbiter_if: master-side and slave-side Wishbone B3 signals of the tile RAM arbiter,
// with per-master fields packed as flat slices (master k at [k*width +: width]).
interface ct_ram_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int aw = 32,
   parameter int dw = 32
);
   logic [NUM_MASTERS*aw-1:0]   m_adr_i;
   logic [NUM_MASTERS*dw-1:0]   m_dat_i;
   logic [NUM_MASTERS*dw/8-1:0] m_sel_i;
   logic [NUM_MASTERS*3-1:0]    m_cti_i;
   logic [NUM_MASTERS*2-1:0]    m_bte_i;
   logic [NUM_MASTERS-1:0]      m_we_i;
   logic [NUM_MASTERS-1:0]      m_cyc_i;
   logic [NUM_MASTERS-1:0]      m_stb_i;
   logic [dw-1:0]               m_dat_o;
   logic [NUM_MASTERS-1:0]      m_ack_o;
   logic [NUM_MASTERS-1:0]      m_err_o;
   logic [NUM_MASTERS-1:0]      m_rty_o;
   logic [aw-1:0]               s_adr_o;
   logic [dw-1:0]               s_dat_o;
   logic [dw/8-1:0]             s_sel_o;
   logic [2:0]                  s_cti_o;
   logic [1:0]                  s_bte_o;
   logic                        s_we_o;
   logic                        s_cyc_o;
   logic                        s_stb_o;
   logic [dw-1:0]               s_dat_i;
   logic                        s_ack_i;
   logic                        s_err_i;
   logic                        s_rty_i;
   logic [NUM_MASTERS-1:0]      grant_o;

   modport slave (
      input  m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_we_i, m_cyc_i, m_stb_i,
      input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
      output m_dat_o, m_ack_o, m_err_o, m_rty_o,
      output s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_we_o, s_cyc_o, s_stb_o, grant_o
   );

   modport master (
      output m_adr_i, m_dat_i, m_sel_i, m_cti_i, m_bte_i, m_we_i, m_cyc_i, m_stb_i,
      output s_dat_i, s_ack_i, s_err_i, s_rty_i,
      input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
      input  s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o, s_we_o, s_cyc_o, s_stb_o, grant_o
   );
endinterface

// File: rtl/ct_ram_arbiter.sv
// ct_ram_arbiter: round-robin Wishbone B3 arbiter sharing one tile RAM slave port;
// a grant is held for the whole cyc so bursts are never split.
module ct_ram_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int aw = 32,
   parameter int dw = 32
) (
   input logic wb_clk_i,
   input logic wb_rst_ni,
   ct_ram_arbiter_if.slave bus
);
   localparam int N  = NUM_MASTERS;
   localparam int LW = N > 1 ? $clog2(N) : 1;

   logic [N-1:0]  grant, grant_nxt;
   logic [LW-1:0] last, last_nxt;
   logic          owner_cyc;

   assign owner_cyc = |(grant & bus.m_cyc_i);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
      if (!wb_rst_ni) begin
         grant <= '0;
         last  <= LW'(N - 1);
      end else begin
         grant <= grant_nxt;
         last  <= last_nxt;
      end

   // scan from farthest to nearest after last, so the nearest requester is written last and wins
   always_comb begin
      grant_nxt = grant;
      last_nxt  = last;
      if (!owner_cyc) begin
         grant_nxt = '0;
         for (int i = N; i >= 1; i--)
            if (bus.m_cyc_i[(int'(last) + i) % N]) begin
               grant_nxt = '0;
               grant_nxt[(int'(last) + i) % N] = 1'b1;
               last_nxt = LW'((int'(last) + i) % N);
            end
      end
   end

   always_comb begin
      bus.s_adr_o = '0;
      bus.s_dat_o = '0;
      bus.s_sel_o = '0;
      bus.s_cti_o = '0;
      bus.s_bte_o = '0;
      bus.s_we_o  = 1'b0;
      for (int k = 0; k < N; k++)
         if (grant[k]) begin
            bus.s_adr_o = bus.m_adr_i[k*aw +: aw];
            bus.s_dat_o = bus.m_dat_i[k*dw +: dw];
            bus.s_sel_o = bus.m_sel_i[k*(dw/8) +: dw/8];
            bus.s_cti_o = bus.m_cti_i[k*3 +: 3];
            bus.s_bte_o = bus.m_bte_i[k*2 +: 2];
            bus.s_we_o  = bus.m_we_i[k];
         end
   end

   assign bus.s_cyc_o = owner_cyc;
   assign bus.s_stb_o = |(grant & bus.m_cyc_i & bus.m_stb_i);
   assign bus.m_ack_o = grant & {N{bus.s_ack_i}};
   assign bus.m_err_o = grant & {N{bus.s_err_i}};
   assign bus.m_rty_o = grant & {N{bus.s_rty_i}};
   assign bus.m_dat_o = bus.s_dat_i;
   assign bus.grant_o = grant;
endmodule

// File: tb/tb_ct_ram_arbiter.sv
// tb_ct_ram_arbiter: directed two-master bench for ct_ram_arbiter with immediate assertions.
module tb_ct_ram_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ct_ram_arbiter_if #(.NUM_MASTERS(2), .aw(32), .dw(32)) bus ();

   ct_ram_arbiter #(.NUM_MASTERS(2), .aw(32), .dw(32)) dut (
      .wb_clk_i (clk),
      .wb_rst_ni(rst_n),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [1:0] exp_g;

   initial begin
      bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_cti_i = '0;
      bus.m_bte_i = '0; bus.m_we_i = '0; bus.m_cyc_i = '0; bus.m_stb_i = '0;
      bus.s_dat_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
      #2;
      chk("rst_grant", 64'(bus.grant_o), 64'h0);
      chk("rst_scyc", 64'(bus.s_cyc_o), 64'h0);
      #10;
      rst_n = 1'b1;
      // single read by master 0
      bus.m_adr_i[31:0] = 32'h100;
      bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; bus.m_sel_i[3:0] = 4'hf;
      #1;
      chk("req_no_grant_yet", 64'(bus.grant_o), 64'h0);
      chk("idle_adr_zero", 64'(bus.s_adr_o), 64'h0);
      tick();
      chk("t1_grant", 64'(bus.grant_o), 64'h1);
      chk("t1_adr", 64'(bus.s_adr_o), 64'h100);
      chk("t1_scyc", 64'(bus.s_cyc_o), 64'h1);
      chk("t1_sstb", 64'(bus.s_stb_o), 64'h1);
      bus.s_ack_i = 1'b1; bus.s_dat_i = 32'hcafe_f00d;
      #1;
      chk("t1_ack", 64'(bus.m_ack_o), 64'h1);
      chk("t1_dat", 64'(bus.m_dat_o), 64'hcafe_f00d);
      tick();
      bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
      #1;
      chk("t1_drop_scyc", 64'(bus.s_cyc_o), 64'h0);
      tick();
      chk("t1_idle", 64'(bus.grant_o), 64'h0);
      // both masters issue back-to-back single reads; last granted was 0 so master 1 leads
      bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
      tick();
      exp_g = 2'b10;
      for (int t = 0; t < 4; t++) begin
         bus.m_cyc_i = 2'b11; bus.s_ack_i = 1'b1;
         #1;
         chk($sformatf("rr_grant%0d", t), 64'(bus.grant_o), 64'(exp_g));
         chk($sformatf("rr_ack%0d", t), 64'(bus.m_ack_o), 64'(exp_g));
         tick();
         bus.m_cyc_i = ~exp_g; bus.s_ack_i = 1'b0;
         tick();
         exp_g = ~exp_g;
      end
      bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
      tick();
      chk("rr_idle", 64'(bus.grant_o), 64'h0);
      // master 0 wrap-4 burst while master 1 waits
      bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
      bus.m_cti_i = 6'b000_010; bus.m_bte_i = 4'b00_01; bus.m_adr_i[31:0] = 32'h208;
      tick();
      for (int b = 0; b < 4; b++) begin
         if (b == 3) bus.m_cti_i[2:0] = 3'b111;
         bus.s_ack_i = 1'b1;
         #1;
         chk($sformatf("burst_grant%0d", b), 64'(bus.grant_o), 64'h1);
         chk($sformatf("burst_ack%0d", b), 64'(bus.m_ack_o), 64'h1);
         chk($sformatf("burst_cti%0d", b), 64'(bus.s_cti_o), b == 3 ? 64'h7 : 64'h2);
         tick();
      end
      chk("burst_bte", 64'(bus.s_bte_o), 64'h1);
      bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b10; bus.m_cti_i = '0; bus.m_bte_i = '0;
      #1;
      chk("burst_drop_scyc", 64'(bus.s_cyc_o), 64'h0);
      tick();
      chk("handover_grant", 64'(bus.grant_o), 64'h2);
      chk("handover_scyc", 64'(bus.s_cyc_o), 64'h1);
      // master 1 holds cyc with stb low; master 0 must stay blocked
      bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b01;
      for (int w = 0; w < 5; w++) begin
         #1;
         chk($sformatf("wait_stb%0d", w), 64'(bus.s_stb_o), 64'h0);
         chk($sformatf("wait_grant%0d", w), 64'(bus.grant_o), 64'h2);
         tick();
      end
      // slave errors master 1's write
      bus.m_stb_i = 2'b11; bus.m_we_i = 2'b10;
      bus.m_sel_i[7:4] = 4'b0011; bus.m_dat_i[63:32] = 32'h55aa_1234; bus.m_adr_i[63:32] = 32'h40;
      bus.s_err_i = 1'b1;
      #1;
      chk("err_err", 64'(bus.m_err_o), 64'h2);
      chk("err_ack", 64'(bus.m_ack_o), 64'h0);
      chk("err_we", 64'(bus.s_we_o), 64'h1);
      chk("err_sel", 64'(bus.s_sel_o), 64'h3);
      chk("err_dat", 64'(bus.s_dat_o), 64'h55aa_1234);
      chk("err_adr", 64'(bus.s_adr_o), 64'h40);
      tick();
      bus.s_err_i = 1'b0; bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; bus.m_we_i = 2'b00;
      tick();
      chk("pre_rst_grant", 64'(bus.grant_o), 64'h1);
      // reset in the middle of master 0's cycle
      bus.s_ack_i = 1'b1;
      #1;
      chk("pre_rst_ack", 64'(bus.m_ack_o), 64'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_grant", 64'(bus.grant_o), 64'h0);
      chk("rst_mid_scyc", 64'(bus.s_cyc_o), 64'h0);
      chk("rst_mid_sstb", 64'(bus.s_stb_o), 64'h0);
      chk("rst_mid_ack", 64'(bus.m_ack_o), 64'h0);
      bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
      #1;
      rst_n = 1'b1;
      tick();
      chk("post_rst_grant", 64'(bus.grant_o), 64'h1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
